// File: rtl/uart_rx_lite.sv
// Oversampling UART receiver: 2-flop synchronizer, mid-bit sampling, optional even parity.
// Reports each frame as a one-clock valid (with parity_err) or frame_err pulse; the line has no backpressure.
module uart_rx_lite #(
  parameter int DATA_W    = 8,
  parameter int OS        = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = (OS > 1) ? $clog2(OS) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF     = CW'(OS / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(OS - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic              rxd_m;
  logic              rxd_s;

  // Synchronizer resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            state <= rxd_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= {rxd_s, shreg[DATA_W-1:1]};
            if (idx == LAST_BIT) begin
              state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            par   <= rxd_s;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            // Returning to IDLE right at the mid-stop sample leaves half a bit to catch a back-to-back start.
            if (rxd_s) begin
              data       <= shreg;
              valid      <= 1'b1;
              parity_err <= (PARITY_EN != 0) && (par != (^shreg));
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_lite.sv
// Directed and randomized frames for uart_rx_lite, checked against a frame-level expectation queue.
module tb_uart_rx_lite;

  localparam int DW = 8;
  localparam int OS = 4;
  localparam int PE = 1;

  typedef struct packed {
    logic          v;
    logic          pe;
    logic          fe;
    logic [DW-1:0] d;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxd;
  logic [DW-1:0] data;
  logic          valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  ev_t           obs_q[$];
  ev_t           exp_q[$];
  logic [DW-1:0] last_data;

  uart_rx_lite #(.DATA_W(DW), .OS(OS), .PARITY_EN(PE)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Any output pulse becomes one observed event; a stretched pulse shows up as an extra event.
  always @(negedge clk) begin
    if (rst && (valid || parity_err || frame_err))
      obs_q.push_back('{v: valid, pe: parity_err, fe: frame_err, d: data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    repeat (n) @(negedge clk);
  endtask

  // One frame on the line, plus the outcome the receiver must report for it.
  task automatic send_frame(input logic [DW-1:0] d, input bit flip, input bit stop_ok, input int stop_cycles);
    drive_bit(1'b0, OS);
    for (int i = 0; i < DW; i++) drive_bit(d[i], OS);
    if (PE != 0) drive_bit((^d) ^ flip, OS);
    drive_bit(stop_ok, stop_cycles);
    if (stop_ok) begin
      exp_q.push_back('{v: 1'b1, pe: (PE != 0) && flip, fe: 1'b0, d: d});
      last_data = d;
    end else begin
      exp_q.push_back('{v: 1'b0, pe: 1'b0, fe: 1'b1, d: last_data});
    end
  endtask

  task automatic drain(input string tag);
    int  t;
    ev_t o;
    ev_t e;
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (3 * OS) @(negedge clk);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_valid"}, o.v, e.v);
      chk({tag, "_perr"}, o.pe, e.pe);
      chk({tag, "_ferr"}, o.fe, e.fe);
      chk({tag, "_data"}, o.d, e.d);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int t;
    rst       = 1'b0;
    rxd       = 1'b1;
    last_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'hA5, 1'b0, 1'b1, OS);
    drive_bit(1'b1, 4);
    drain("a5");
    chk("a5_busy", busy, 0);

    send_frame(8'h3C, 1'b1, 1'b1, OS);
    drive_bit(1'b1, 4);
    drain("3c");

    send_frame(8'h55, 1'b0, 1'b0, 3 * OS);
    chk("break_busy_hi", busy, 1);
    rxd = 1'b1;
    t = 0;
    while (busy && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("break_busy_lo", busy, 0);
    drain("55brk");

    // Single-clock low glitch.
    drive_bit(1'b0, 1);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    repeat (OS / 2) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    drain("glitch");

    // Reset halfway through data bit 4 of 0xFF.
    drive_bit(1'b0, OS);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, OS);
    drive_bit(1'b1, OS / 2);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", data, 0);
    rst       = 1'b1;
    last_data = '0;
    repeat (4) @(negedge clk);
    drain("aborted");
    send_frame(8'h81, 1'b0, 1'b1, OS);
    drive_bit(1'b1, 4);
    drain("81");

    send_frame(8'h01, 1'b0, 1'b1, OS);
    send_frame(8'h80, 1'b0, 1'b1, OS);
    send_frame(8'h00, 1'b0, 1'b1, OS);
    drive_bit(1'b1, 4);
    drain("b2b");

    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] d;
      bit            flip;
      bit            sok;
      d    = DW'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      sok  = ($urandom_range(0, 5) != 0);
      if (sok) begin
        send_frame(d, flip, 1'b1, OS);
        drive_bit(1'b1, $urandom_range(0, 3));
      end else begin
        send_frame(d, flip, 1'b0, OS * $urandom_range(1, 3));
        drive_bit(1'b1, 6);
      end
    end
    drive_bit(1'b1, 4);
    drain("rand");
    chk("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
